// File: rtl/mem_access_unit.sv
// Load/store sequencer: one RISC-V B/H/W access -> valid/ready word transaction with byte strobes.
// Optional abort on memory stall: define MEM_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] ReadData,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] read_data_q, read_data_d;
    logic        timeout;

    function automatic logic access_illegal(input logic w, input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        if (w && f3[2]) bad = 1'b1;
        if ((f3[1:0] == 2'b01) && a[0]) bad = 1'b1;
        if ((f3[1:0] == 2'b10) && (a != 2'b00)) bad = 1'b1;
        return bad;
    endfunction

    // funct3[2] selects zero-extension; the lane is shifted down to bit 0 first
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rdata);
        logic [31:0] lane;
        logic        sgn;
        lane = rdata >> {a, 3'b000};
        case (f3[1:0])
            2'b00: begin
                sgn = lane[7] & ~f3[2];
                return {{24{sgn}}, lane[7:0]};
            end
            2'b01: begin
                sgn = lane[15] & ~f3[2];
                return {{16{sgn}}, lane[15:0]};
            end
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts ACCESS cycles; held at zero everywhere else so each access starts fresh
    always_comb begin
        cnt_d = '0;
        if (state_q == ACCESS) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign timeout = (state_q == ACCESS) && !mem_ready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            err_q       <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            read_data_q <= read_data_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q     <= we_d;
        funct3_q <= funct3_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = access_illegal(we, funct3, addr[1:0]) ? RESP : ACCESS;
            ACCESS:  if (mem_ready || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        read_data_d = read_data_q;
        if ((state_q == IDLE) && req) begin
            we_d     = we;
            funct3_d = funct3;
            addr_d   = addr;
            wdata_d  = wdata;
            err_d    = access_illegal(we, funct3, addr[1:0]);
        end
        if (timeout) err_d = 1'b1;
        if ((state_q == ACCESS) && mem_ready && !we_q)
            read_data_d = load_extend(funct3_q, addr_q[1:0], mem_rdata);
    end

    // Memory-side outputs are forced to zero outside ACCESS so nothing stale leaks out
    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == RESP);
        err       = (state_q == RESP) && err_q;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wstrb = '0;
        mem_wdata = '0;
        if (state_q == ACCESS) begin
            mem_valid = 1'b1;
            mem_we    = we_q;
            mem_addr  = {addr_q[31:2], 2'b00};
            if (we_q) begin
                mem_wstrb = store_strb(funct3_q, addr_q[1:0]);
                mem_wdata = store_data(funct3_q, wdata_q);
            end
        end
    end

    assign ReadData = read_data_q;

endmodule
